// File: rtl/neuron_stream_loader_pkg.sv
// Shared definitions for the neuron_stream_loader byte-stream front end:
// frame command encodings, loader FSM states and the PARAMS frame length.
package neuron_stream_loader_pkg;

  typedef enum logic [1:0] {
    CMD_WEIGHTS = 2'b00,
    CMD_INPUTS  = 2'b01,
    CMD_PARAMS  = 2'b10,
    CMD_STEP    = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_LOAD   = 2'b01,
    S_COMMIT = 2'b10,
    S_STEP   = 2'b11
  } state_e;

  localparam int PARAM_BYTES = 3;

endpackage

// File: rtl/neuron_stream_loader_byte_shift_assembler.sv
// Shadow register for the loader: each accepted byte lands in the byte lane
// selected by idx_i, so a frame is assembled LSB byte first.
module byte_shift_assembler #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 3
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [7:0]       byte_i,
  output logic [WIDTH-1:0] shadow_o
);

  localparam int NBYTES = WIDTH / 8;

  logic [WIDTH-1:0] shadow_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      shadow_q <= '0;
    end else if (we_i) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (idx_i == IDX_W'(k)) shadow_q[8*k +: 8] <= byte_i;
      end
    end
  end

  assign shadow_o = shadow_q;

endmodule

// File: rtl/neuron_stream_loader.sv
// Byte-stream loader feeding neuron_lif: assembles frames in a shadow register,
// commits them atomically to the active outputs and sequences STEP pulses.
module neuron_stream_loader
  import neuron_stream_loader_pkg::*;
#(
  parameter int SYNAPSES              = 32,
  parameter int MEMBRANE_BITS         = $clog2(SYNAPSES) + 2,
  parameter int THRESHOLD_BITS        = MEMBRANE_BITS - 1,
  parameter int BATCHNORM_ADDEND_BITS = MEMBRANE_BITS - 2
) (
  input  logic                                    clk_i,
  input  logic                                    reset_i,
  input  logic [1:0]                              cmd_i,
  input  logic [7:0]                              data_in_i,
  input  logic                                    data_valid_i,
  output logic                                    data_ready_o,
  output logic [SYNAPSES-1:0]                     weights_o,
  output logic [SYNAPSES-1:0]                     inputs_o,
  output logic [2:0]                              shift_o,
  output logic [3:0]                              batchnorm_factor_o,
  output logic signed [BATCHNORM_ADDEND_BITS-1:0] batchnorm_addend_o,
  output logic [THRESHOLD_BITS-1:0]               threshold_o,
  output logic                                    neuron_enable_o,
  input  logic                                    neuron_spike_i,
  output logic                                    spike_out_o,
  output logic                                    spike_valid_o,
  output logic                                    busy_o
);

  localparam int VEC_BYTES = SYNAPSES / 8;
  // At least 2 bits so a 3-byte PARAMS frame can be counted even when SYNAPSES=8.
  localparam int IDX_W = ($clog2(VEC_BYTES) + 1 < 2) ? 2 : $clog2(VEC_BYTES) + 1;
  localparam int SH_W  = (SYNAPSES > 8 * PARAM_BYTES) ? SYNAPSES : 8 * PARAM_BYTES;

  state_e           state_q, state_d;
  cmd_e             cmd_q, cmd_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] wr_idx;
  logic             wr_en, commit, xfer;
  logic [SH_W-1:0]  shadow;

  logic [SYNAPSES-1:0]                     weights_q, inputs_q;
  logic [2:0]                              shift_q;
  logic [3:0]                              bnf_q;
  logic signed [BATCHNORM_ADDEND_BITS-1:0] addend_q;
  logic [THRESHOLD_BITS-1:0]               thr_q;
  logic                                    spike_out_q, spike_valid_q;

  function automatic logic [IDX_W-1:0] last_idx(input cmd_e c);
    return (c == CMD_PARAMS) ? IDX_W'(PARAM_BYTES - 1) : IDX_W'(VEC_BYTES - 1);
  endfunction

  assign xfer = data_valid_i & data_ready_o;

  byte_shift_assembler #(.WIDTH(SH_W), .IDX_W(IDX_W)) u_shadow (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .we_i     (wr_en),
    .idx_i    (wr_idx),
    .byte_i   (data_in_i),
    .shadow_o (shadow)
  );

  always_comb begin
    state_d         = state_q;
    cmd_d           = cmd_q;
    idx_d           = idx_q;
    wr_en           = 1'b0;
    wr_idx          = idx_q;
    commit          = 1'b0;
    data_ready_o    = 1'b0;
    neuron_enable_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        data_ready_o = 1'b1;
        wr_idx       = '0;
        if (xfer) begin
          cmd_d = cmd_e'(cmd_i);
          idx_d = IDX_W'(1);
          if (cmd_e'(cmd_i) == CMD_STEP) begin
            state_d = S_STEP;
          end else begin
            wr_en   = 1'b1;
            state_d = (last_idx(cmd_e'(cmd_i)) == '0) ? S_COMMIT : S_LOAD;
          end
        end
      end
      S_LOAD: begin
        data_ready_o = 1'b1;
        if (xfer) begin
          wr_en = 1'b1;
          if (idx_q == last_idx(cmd_q)) state_d = S_COMMIT;
          else                          idx_d   = idx_q + IDX_W'(1);
        end
      end
      S_COMMIT: begin
        commit  = 1'b1;
        state_d = S_IDLE;
      end
      S_STEP: begin
        neuron_enable_o = 1'b1;
        state_d         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cmd_q   <= CMD_WEIGHTS;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      idx_q   <= idx_d;
    end
  end

  // Active registers change only on COMMIT, and only the one named by the frame.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      weights_q <= '0;
      inputs_q  <= '0;
      shift_q   <= '0;
      bnf_q     <= '0;
      thr_q     <= '0;
      addend_q  <= '0;
    end else if (commit) begin
      case (cmd_q)
        CMD_WEIGHTS: weights_q <= shadow[SYNAPSES-1:0];
        CMD_INPUTS:  inputs_q  <= shadow[SYNAPSES-1:0];
        CMD_PARAMS: begin
          shift_q  <= shadow[2:0];
          bnf_q    <= shadow[7:4];
          thr_q    <= shadow[8 +: THRESHOLD_BITS];
          addend_q <= $signed(shadow[16 +: BATCHNORM_ADDEND_BITS]);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      spike_out_q   <= 1'b0;
      spike_valid_q <= 1'b0;
    end else begin
      spike_valid_q <= (state_q == S_STEP);
      if (state_q == S_STEP) spike_out_q <= neuron_spike_i;
    end
  end

  assign weights_o          = weights_q;
  assign inputs_o           = inputs_q;
  assign shift_o            = shift_q;
  assign batchnorm_factor_o = bnf_q;
  assign batchnorm_addend_o = addend_q;
  assign threshold_o        = thr_q;
  assign spike_out_o        = spike_out_q;
  assign spike_valid_o      = spike_valid_q;
  assign busy_o             = (state_q != S_IDLE);

endmodule

// File: tb/tb_neuron_stream_loader.sv
// Self-checking bench for neuron_stream_loader (SYNAPSES=32): directed frames plus
// a randomized frame sequence scored against a frame-level model of the active registers.
module tb_neuron_stream_loader;

  localparam int SYN = 32;
  localparam int THR = 6;
  localparam int BNA = 5;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic [1:0]            cmd = 2'b00;
  logic [7:0]            data_in = 8'h00;
  logic                  data_valid = 1'b0;
  logic                  data_ready;
  logic [SYN-1:0]        weights, inputs;
  logic [2:0]            shift;
  logic [3:0]            bn_factor;
  logic signed [BNA-1:0] bn_addend;
  logic [THR-1:0]        threshold;
  logic                  neuron_enable;
  logic                  neuron_spike = 1'b0;
  logic                  spike_out, spike_valid, busy;

  int checks = 0;
  int errors = 0;

  // Frame-level reference state
  logic [SYN-1:0] m_w, m_in;
  int             m_shift, m_bnf, m_thr, m_add;
  logic           m_spk;

  always #5 clk = ~clk;

  neuron_stream_loader #(.SYNAPSES(SYN)) dut (
    .clk_i              (clk),
    .reset_i            (reset),
    .cmd_i              (cmd),
    .data_in_i          (data_in),
    .data_valid_i       (data_valid),
    .data_ready_o       (data_ready),
    .weights_o          (weights),
    .inputs_o           (inputs),
    .shift_o            (shift),
    .batchnorm_factor_o (bn_factor),
    .batchnorm_addend_o (bn_addend),
    .threshold_o        (threshold),
    .neuron_enable_o    (neuron_enable),
    .neuron_spike_i     (neuron_spike),
    .spike_out_o        (spike_out),
    .spike_valid_o      (spike_valid),
    .busy_o             (busy)
  );

  task automatic model_reset();
    m_w = '0; m_in = '0; m_shift = 0; m_bnf = 0; m_thr = 0; m_add = 0; m_spk = 1'b0;
  endtask

  task automatic model_apply(input logic [1:0] c, input logic [7:0] q[$], input logic spk);
    logic [SYN-1:0] v;
    v = '0;
    case (c)
      2'b00, 2'b01: begin
        for (int k = 0; k < q.size(); k++) v = v | (SYN'(q[k]) << (8 * k));
        if (c == 2'b00) m_w = v; else m_in = v;
      end
      2'b10: begin
        m_shift = int'(q[0]) % 8;
        m_bnf   = int'(q[0]) / 16;
        m_thr   = int'(q[1]) % 64;
        m_add   = int'(q[2]) % 32;
        if (m_add >= 16) m_add = m_add - 32;
      end
      default: m_spk = spk;
    endcase
  endtask

  // Presents one byte and returns #1 after the edge on which it was accepted.
  task automatic send_byte(input logic [1:0] c, input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    cmd = c; data_in = d; data_valid = 1'b1;
    while (!data_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!data_ready) begin
      errors++;
      $display("FAIL ready_timeout data_ready=%0b required 1 within 20 cycles", data_ready);
    end
    @(posedge clk);
    #1 data_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [1:0] c, input logic [7:0] q[$]);
    for (int k = 0; k < q.size(); k++) send_byte(c, q[k]);
  endtask

  task automatic test_reset();
    int en_seen;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    @(negedge clk);
    checks++; if (weights !== '0) begin errors++; $display("FAIL reset_weights got %h want 0", weights); end
    checks++; if (inputs !== '0) begin errors++; $display("FAIL reset_inputs got %h want 0", inputs); end
    checks++; if ({shift, bn_factor, bn_addend, threshold} !== '0) begin errors++;
      $display("FAIL reset_params got %h/%h/%h/%h want 0", shift, bn_factor, bn_addend, threshold); end
    checks++; if ({spike_out, spike_valid, busy} !== 3'b000) begin errors++;
      $display("FAIL reset_flags got so=%b sv=%b busy=%b want 000", spike_out, spike_valid, busy); end
    checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", data_ready); end
    en_seen = 0;
    repeat (6) begin
      if (neuron_enable !== 1'b0) en_seen++;
      @(negedge clk);
    end
    checks++; if (en_seen != 0) begin errors++; $display("FAIL idle_enable got %0d pulses want 0", en_seen); end
  endtask

  task automatic test_weights();
    logic [7:0] q[$];
    q = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(2'b00, q);
    model_apply(2'b00, q, 1'b0);
    @(negedge clk);
    checks++; if (weights !== '0) begin errors++; $display("FAIL weights_early got %h want 0", weights); end
    checks++; if ({data_ready, busy} !== 2'b01) begin errors++;
      $display("FAIL commit_cycle got ready=%b busy=%b want ready=0 busy=1", data_ready, busy); end
    @(negedge clk);
    checks++; if (weights !== 32'h44332211) begin errors++; $display("FAIL weights_value got %h want 44332211", weights); end
    checks++; if (weights !== m_w) begin errors++; $display("FAIL weights_model got %h want %h", weights, m_w); end
  endtask

  task automatic test_params();
    logic [7:0] q[$];
    q = '{8'hA5, 8'h0C, 8'h1F};
    send_frame(2'b10, q);
    model_apply(2'b10, q, 1'b0);
    repeat (2) @(negedge clk);
    checks++; if (bn_factor !== 4'hA) begin errors++; $display("FAIL params_bnf got %h want a", bn_factor); end
    checks++; if (shift !== 3'd5) begin errors++; $display("FAIL params_shift got %0d want 5", shift); end
    checks++; if (threshold !== 6'd12) begin errors++; $display("FAIL params_thr got %0d want 12", threshold); end
    checks++; if (int'(bn_addend) != -1) begin errors++; $display("FAIL params_addend got %0d want -1", bn_addend); end
    checks++; if (weights !== m_w || inputs !== m_in) begin errors++;
      $display("FAIL params_vectors got w=%h i=%h want w=%h i=%h", weights, inputs, m_w, m_in); end
  endtask

  task automatic test_inputs_stall();
    logic [7:0] q[$];
    logic [7:0] a[$];
    logic [7:0] b[$];
    int gap_bad;
    for (int k = 0; k < SYN / 8; k++) q.push_back(8'($urandom));
    a = q[0:1];
    b = q[2:3];
    send_frame(2'b01, a);
    gap_bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (data_ready !== 1'b1 || busy !== 1'b1) gap_bad++;
    end
    checks++; if (gap_bad != 0) begin errors++; $display("FAIL stall_ready got %0d bad gap cycles want 0", gap_bad); end
    send_frame(2'b01, b);
    model_apply(2'b01, q, 1'b0);
    repeat (2) @(negedge clk);
    checks++; if (inputs !== m_in) begin errors++; $display("FAIL stall_inputs got %h want %h", inputs, m_in); end
    checks++; if (weights !== m_w) begin errors++; $display("FAIL stall_weights got %h want %h", weights, m_w); end
  endtask

  task automatic test_step();
    neuron_spike = 1'b0;
    send_byte(2'b11, 8'h5A);
    neuron_spike = 1'b1;
    @(negedge clk);
    checks++; if ({neuron_enable, spike_valid, data_ready} !== 3'b100) begin errors++;
      $display("FAIL step_enable got en=%b sv=%b rdy=%b want 100", neuron_enable, spike_valid, data_ready); end
    @(posedge clk);
    #1 neuron_spike = 1'b0;
    @(negedge clk);
    checks++; if ({neuron_enable, spike_valid, spike_out} !== 3'b011) begin errors++;
      $display("FAIL step_valid got en=%b sv=%b so=%b want 011", neuron_enable, spike_valid, spike_out); end
    repeat (4) @(negedge clk);
    checks++; if ({spike_valid, spike_out} !== 2'b01) begin errors++;
      $display("FAIL step_hold got sv=%b so=%b want 01", spike_valid, spike_out); end
    m_spk = 1'b1;
  endtask

  task automatic test_reset_midframe();
    logic [7:0] q[$];
    int sv_seen;
    q = '{8'h99, 8'h88};
    send_frame(2'b00, q);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    @(negedge clk);
    checks++; if ({busy, data_ready, spike_out} !== 3'b010 || weights !== '0) begin errors++;
      $display("FAIL midreset_state got busy=%b rdy=%b so=%b w=%h want 0 1 0 0", busy, data_ready, spike_out, weights); end
    q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_frame(2'b00, q);
    model_apply(2'b00, q, 1'b0);
    repeat (2) @(negedge clk);
    checks++; if (weights !== 32'hDEADBEEF) begin errors++; $display("FAIL midreset_weights got %h want deadbeef", weights); end
    neuron_spike = 1'b1;
    send_byte(2'b11, 8'h00);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    neuron_spike = 1'b0;
    model_reset();
    sv_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (spike_valid !== 1'b0) sv_seen++;
    end
    checks++; if (sv_seen != 0 || spike_out !== 1'b0) begin errors++;
      $display("FAIL step_reset got %0d spike_valid cycles so=%b want 0 0", sv_seen, spike_out); end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic [1:0] c;
    logic       spk;
    int         len;
    for (int it = 0; it < 40; it++) begin
      c   = 2'($urandom_range(0, 3));
      spk = 1'($urandom);
      len = (c == 2'b10) ? 3 : (c == 2'b11) ? 1 : SYN / 8;
      q.delete();
      for (int k = 0; k < len; k++) q.push_back(8'($urandom));
      neuron_spike = spk;
      send_frame(c, q);
      model_apply(c, q, spk);
      repeat (2) @(negedge clk);
      neuron_spike = 1'b0;
      checks++; if (weights !== m_w) begin errors++; $display("FAIL rand_weights it=%0d got %h want %h", it, weights, m_w); end
      checks++; if (inputs !== m_in) begin errors++; $display("FAIL rand_inputs it=%0d got %h want %h", it, inputs, m_in); end
      checks++; if (int'(shift) != m_shift || int'(bn_factor) != m_bnf) begin errors++;
        $display("FAIL rand_shift_bnf it=%0d got %0d/%0d want %0d/%0d", it, shift, bn_factor, m_shift, m_bnf); end
      checks++; if (int'(threshold) != m_thr || int'(bn_addend) != m_add) begin errors++;
        $display("FAIL rand_thr_add it=%0d got %0d/%0d want %0d/%0d", it, threshold, bn_addend, m_thr, m_add); end
      checks++; if (spike_out !== m_spk) begin errors++; $display("FAIL rand_spike it=%0d got %b want %b", it, spike_out, m_spk); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rand_idle it=%0d busy=%b want 0", it, busy); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_weights();
    test_params();
    test_inputs_stall();
    test_step();
    test_reset_midframe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
